// File: rtl/line_replay_buffer_if.sv
// line_replay_buffer_if: write/read handshake bundle for the double-banked line replay buffer
interface line_replay_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int REP_W  = 2
);
  logic [ADDR_W:0]   line_len;
  logic [REP_W-1:0]  repeat_cnt;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_avail;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              overflow;
  modport master (
    output line_len, repeat_cnt, wr_valid, wr_data, rd_req,
    input  wr_ready, rd_avail, rd_valid, rd_data, rd_last, overflow
  );
  modport slave (
    input  line_len, repeat_cnt, wr_valid, wr_data, rd_req,
    output wr_ready, rd_avail, rd_valid, rd_data, rd_last, overflow
  );
endinterface

// File: rtl/line_replay_buffer.sv
// line_replay_buffer: two line banks, one filled while the other is replayed 1..2**REP_W times
module line_replay_buffer #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 640,
  parameter int ADDR_W  = 10,
  parameter int REP_W   = 2
) (
  input logic clock,
  input logic reset,
  line_replay_buffer_if.slave bus
);
  localparam logic [ADDR_W:0] MAX = (ADDR_W+1)'(MAX_LEN);
  typedef enum logic {IDLE, READ} state_t;
  state_t state;
  logic run, wb, rb, overflow, rd_valid, rd_last;
  logic [1:0] full;
  logic [ADDR_W:0] wi, ri, in_len, wlen;
  logic [ADDR_W:0] len_q [2];
  logic [REP_W-1:0] pass, rep, rep_eff;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [2][MAX_LEN];
  logic wr_ready, rd_avail, wr_fire, rd_fire, wr_end, rd_end, rd_done;
  // run holds every output low for the first cycle after reset release
  assign wr_ready = run & ~full[wb];
  assign rd_avail = run & full[rb];
  assign bus.wr_ready = wr_ready;
  assign bus.rd_avail = rd_avail;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.rd_last  = rd_last;
  assign bus.overflow = overflow;
  always_comb begin
    in_len  = (bus.line_len == '0 || bus.line_len > MAX) ? MAX : bus.line_len;
    wlen    = wi == '0 ? in_len : len_q[wb];
    wr_fire = bus.wr_valid & wr_ready;
    wr_end  = wi == wlen - 1'b1;
    rd_fire = bus.rd_req & rd_avail;
    rd_end  = ri == len_q[rb] - 1'b1;
    rep_eff = state == IDLE ? bus.repeat_cnt : rep;
    rd_done = rd_end && pass == rep_eff;
  end
  always_ff @(posedge clock)
    if (wr_fire) mem[wb][wi[ADDR_W-1:0]] <= bus.wr_data;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run      <= 1'b0;
      overflow <= 1'b0;
      full     <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      wi       <= '0;
      ri       <= '0;
      pass     <= '0;
      rep      <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
      state    <= IDLE;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      run      <= 1'b1;
      rd_valid <= rd_fire;
      rd_last  <= rd_fire & rd_end;
      if (run && bus.wr_valid && !wr_ready) overflow <= 1'b1;
      if (wr_fire) begin
        if (wi == '0) len_q[wb] <= in_len;
        wi <= wr_end ? '0 : wi + 1'b1;
        if (wr_end) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end
      end
      // writer and reader always own different banks, so both full bits may change here
      if (rd_fire) begin
        rd_data <= mem[rb][ri[ADDR_W-1:0]];
        if (state == IDLE) rep <= bus.repeat_cnt;
        state <= rd_done ? IDLE : READ;
        ri    <= rd_end ? '0 : ri + 1'b1;
        pass  <= rd_done ? '0 : rd_end ? pass + 1'b1 : pass;
        if (rd_done) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
        end
      end
    end
  end
endmodule
